// File: rtl/game_pkg.sv
// Shared types and constants for the game master and its win detector.
// Holds the FSM state encoding, result codes and the default board size.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    JUDGE,
    FINISH
  } state_t;

  localparam logic [1:0] RESULT_NONE = 2'd0;
  localparam logic [1:0] RESULT_A    = 2'd1;
  localparam logic [1:0] RESULT_B    = 2'd2;
  localparam logic [1:0] RESULT_DRAW = 2'd3;

  localparam int DEFAULT_N = 3;

endpackage

// File: rtl/win_detect.sv
// Combinational line detector: flags a full row, column or either diagonal
// on an N*N board where cell (r,c) sits at bit r*N+c.
module win_detect
  import game_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N*N-1:0] board,
  output logic           win
);

  logic row_full;
  logic col_full;
  logic diag_full;
  logic anti_full;

  always_comb begin
    win       = 1'b0;
    row_full  = 1'b1;
    col_full  = 1'b1;
    diag_full = 1'b1;
    anti_full = 1'b1;
    for (int i = 0; i < N; i++) begin
      row_full = 1'b1;
      col_full = 1'b1;
      for (int j = 0; j < N; j++) begin
        row_full = row_full & board[i*N+j];
        col_full = col_full & board[j*N+i];
      end
      win       = win | row_full | col_full;
      diag_full = diag_full & board[i*N+i];
      anti_full = anti_full & board[i*N+(N-1-i)];
    end
    win = win | diag_full | anti_full;
  end

endmodule

// File: rtl/game_master.sv
// Referee for a two-player line game: requests moves from an external
// generator, checks each returned board for legality, and detects win/draw.
module game_master
  import game_pkg::*;
#(
  parameter int N       = DEFAULT_N,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             first_a,
  output logic             busy,
  output logic             turn_req,
  input  logic             turn_ready,
  output logic             turn_target_a,
  output logic [N*N-1:0]   turn_board_a,
  output logic [N*N-1:0]   turn_board_b,
  input  logic [N*N-1:0]   turn_board_a_in,
  input  logic [N*N-1:0]   turn_board_b_in,
  input  logic             turn_valid,
  input  logic             turn_error,
  output logic [N*N-1:0]   board_a,
  output logic [N*N-1:0]   board_b,
  output logic             done,
  output logic [1:0]       result,
  output logic             fault
);

  localparam int CELLS = N * N;
  localparam int MW    = $clog2(CELLS + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [MW-1:0]    MOVES_MAX   = MW'(CELLS);
  localparam logic [TW-1:0]    PHASE_LIMIT = TW'(TIMEOUT - 1);
  localparam logic [CELLS-1:0] ONE_CELL    = CELLS'(1);

  state_t           state_q, state_d;
  logic [CELLS-1:0] board_a_q, board_a_d;
  logic [CELLS-1:0] board_b_q, board_b_d;
  logic [CELLS-1:0] ret_a_q, ret_a_d;
  logic [CELLS-1:0] ret_b_q, ret_b_d;
  logic             mover_a_q, mover_a_d;
  logic [MW-1:0]    moves_q, moves_d;
  logic [TW-1:0]    phase_q, phase_d;
  logic [1:0]       result_q, result_d;
  logic             fault_q, fault_d;

  logic [CELLS-1:0] mover_old, mover_new, opp_old, opp_new;
  logic [CELLS-1:0] gained, lost;
  logic [MW-1:0]    moves_inc;
  logic             one_gain, legal, mover_wins;

  // Legality is judged against the boards captured in WAIT, from the mover's view.
  assign mover_old = mover_a_q ? board_a_q : board_b_q;
  assign opp_old   = mover_a_q ? board_b_q : board_a_q;
  assign mover_new = mover_a_q ? ret_a_q   : ret_b_q;
  assign opp_new   = mover_a_q ? ret_b_q   : ret_a_q;
  assign gained    = mover_new & ~mover_old;
  assign lost      = mover_old & ~mover_new;
  assign one_gain  = (gained != '0) && ((gained & (gained - ONE_CELL)) == '0);
  assign legal     = one_gain && (lost == '0) && (opp_new == opp_old) &&
                     ((ret_a_q & ret_b_q) == '0);
  assign moves_inc = moves_q + MW'(1);

  win_detect #(.N(N)) u_win_detect (
    .board (mover_new),
    .win   (mover_wins)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      board_a_q <= '0;
      board_b_q <= '0;
      ret_a_q   <= '0;
      ret_b_q   <= '0;
      mover_a_q <= 1'b0;
      moves_q   <= '0;
      phase_q   <= '0;
      result_q  <= RESULT_NONE;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      board_a_q <= board_a_d;
      board_b_q <= board_b_d;
      ret_a_q   <= ret_a_d;
      ret_b_q   <= ret_b_d;
      mover_a_q <= mover_a_d;
      moves_q   <= moves_d;
      phase_q   <= phase_d;
      result_q  <= result_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    board_a_d = board_a_q;
    board_b_d = board_b_q;
    ret_a_d   = ret_a_q;
    ret_b_d   = ret_b_q;
    mover_a_d = mover_a_q;
    moves_d   = moves_q;
    phase_d   = phase_q;
    result_d  = result_q;
    fault_d   = fault_q;
    turn_req  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          board_a_d = '0;
          board_b_d = '0;
          moves_d   = '0;
          phase_d   = '0;
          result_d  = RESULT_NONE;
          fault_d   = 1'b0;
          mover_a_d = first_a;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (turn_ready) begin
          turn_req = 1'b1;
          phase_d  = '0;
          state_d  = WAIT;
        end else if (phase_q == PHASE_LIMIT) begin
          fault_d = 1'b1;
          state_d = FINISH;
        end else begin
          phase_d = phase_q + TW'(1);
        end
      end
      WAIT: begin
        if (turn_valid) begin
          if (turn_error) begin
            fault_d = 1'b1;
            state_d = FINISH;
          end else begin
            ret_a_d = turn_board_a_in;
            ret_b_d = turn_board_b_in;
            state_d = JUDGE;
          end
        end else if (phase_q == PHASE_LIMIT) begin
          fault_d = 1'b1;
          state_d = FINISH;
        end else begin
          phase_d = phase_q + TW'(1);
        end
      end
      JUDGE: begin
        if (!legal) begin
          fault_d = 1'b1;
          state_d = FINISH;
        end else begin
          board_a_d = ret_a_q;
          board_b_d = ret_b_q;
          moves_d   = moves_inc;
          if (mover_wins) begin
            result_d = mover_a_q ? RESULT_A : RESULT_B;
            state_d  = FINISH;
          end else if (moves_inc == MOVES_MAX) begin
            result_d = RESULT_DRAW;
            state_d  = FINISH;
          end else begin
            mover_a_d = ~mover_a_q;
            phase_d   = '0;
            state_d   = ISSUE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy          = (state_q == ISSUE) || (state_q == WAIT) || (state_q == JUDGE);
  assign done          = (state_q == FINISH);
  assign turn_target_a = mover_a_q;
  assign turn_board_a  = board_a_q;
  assign turn_board_b  = board_b_q;
  assign board_a       = board_a_q;
  assign board_b       = board_b_q;
  assign result        = result_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_game_master.sv
// Bench for game_master: a move-generator model plays games against the DUT
// while an abstract game-rules model predicts boards, result and fault.
module tb_game_master;

  localparam int N           = 3;
  localparam int TIMEOUT     = 255;
  localparam int MODE_LOWEST = 0;
  localparam int MODE_RANDOM = 1;
  localparam int MODE_SCRIPT = 2;
  localparam int MODE_STALL  = 3;
  localparam int NONE        = 99;
  localparam int BUDGET      = 600;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       first_a;
  logic       busy;
  logic       turn_req;
  logic       turn_ready;
  logic       turn_target_a;
  logic [8:0] turn_board_a, turn_board_b;
  logic [8:0] turn_board_a_in, turn_board_b_in;
  logic       turn_valid;
  logic       turn_error;
  logic [8:0] board_a, board_b;
  logic       done;
  logic [1:0] result;
  logic       fault;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int req_count = 0;
  int last_cycles = 0;

  int  gen_mode = MODE_LOWEST;
  int  gen_latency = 3;
  int  bad_move = NONE;
  int  bad_kind = 0;
  int  err_move = NONE;
  bit  noise = 1'b0;
  bit  gen_pending = 1'b0;
  bit  glitch_next = 1'b0;
  bit  req_seen = 1'b0;
  int  gen_count = 0;
  int  script[9];

  logic [8:0] mdl_a, mdl_b;
  bit         mdl_mover_a;
  int         mdl_moves, mdl_attempts;
  logic [1:0] exp_result;
  bit         exp_fault;
  bit         mdl_over;

  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  game_master #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .first_a         (first_a),
    .busy            (busy),
    .turn_req        (turn_req),
    .turn_ready      (turn_ready),
    .turn_target_a   (turn_target_a),
    .turn_board_a    (turn_board_a),
    .turn_board_b    (turn_board_b),
    .turn_board_a_in (turn_board_a_in),
    .turn_board_b_in (turn_board_b_in),
    .turn_valid      (turn_valid),
    .turn_error      (turn_error),
    .board_a         (board_a),
    .board_b         (board_b),
    .done            (done),
    .result          (result),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  function automatic bit cellSet(logic [8:0] v, int i);
    return ((v >> i) & 9'd1) != 9'd0;
  endfunction

  function automatic bit hasLine(logic [8:0] b);
    for (int l = 0; l < 8; l++)
      if (cellSet(b, lines[l][0]) && cellSet(b, lines[l][1]) && cellSet(b, lines[l][2]))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lowestCell(logic [8:0] v);
    for (int i = 0; i < 9; i++)
      if (cellSet(v, i)) return i;
    return -1;
  endfunction

  function automatic int randomCell(logic [8:0] v);
    int n, k;
    n = $countones(v);
    k = $urandom_range(0, n - 1);
    for (int i = 0; i < 9; i++) begin
      if (cellSet(v, i)) begin
        if (k == 0) return i;
        k--;
      end
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Decide the generator's answer and advance the rules model accordingly.
  task automatic deliver();
    logic [8:0] mov, opp, free, nm, no;
    int c, c2;
    bit was_a;
    was_a = mdl_mover_a;
    mov   = was_a ? mdl_a : mdl_b;
    opp   = was_a ? mdl_b : mdl_a;
    free  = ~(mdl_a | mdl_b);
    nm    = mov;
    no    = opp;
    mdl_attempts++;
    if (mdl_moves == err_move) begin
      turn_valid      = 1'b1;
      turn_error      = 1'b1;
      turn_board_a_in = 9'($urandom);
      turn_board_b_in = 9'($urandom);
      exp_fault       = 1'b1;
      mdl_over        = 1'b1;
      return;
    end
    if (mdl_moves == bad_move) begin
      c  = lowestCell(free);
      c2 = lowestCell(free & ~(9'd1 << c));
      case (bad_kind)
        0: nm = mov | (9'd1 << c) | (9'd1 << c2);
        1: begin nm = mov | (9'd1 << c); no = opp | (9'd1 << c2); end
        3: if (opp != 9'd0) nm = mov | (9'd1 << lowestCell(opp));
        default: nm = mov;
      endcase
      exp_fault = 1'b1;
      mdl_over  = 1'b1;
    end else begin
      case (gen_mode)
        MODE_RANDOM: c = randomCell(free);
        MODE_SCRIPT: c = script[mdl_moves];
        default:     c = lowestCell(free);
      endcase
      nm = mov | (9'd1 << c);
      mdl_moves++;
      if (was_a) mdl_a = nm; else mdl_b = nm;
      if (hasLine(nm)) begin
        exp_result = was_a ? 2'd1 : 2'd2;
        mdl_over   = 1'b1;
      end else if (mdl_moves == 9) begin
        exp_result = 2'd3;
        mdl_over   = 1'b1;
      end else begin
        mdl_mover_a = !mdl_mover_a;
      end
    end
    turn_board_a_in = was_a ? nm : no;
    turn_board_b_in = was_a ? no : nm;
    turn_valid      = 1'b1;
    turn_error      = 1'b0;
  endtask

  // Move generator: accepts turn_req, answers after gen_latency cycles.
  initial begin
    turn_ready      = 1'b0;
    turn_valid      = 1'b0;
    turn_error      = 1'b0;
    turn_board_a_in = '0;
    turn_board_b_in = '0;
    forever begin
      @(negedge clk);
      req_seen   = turn_req;
      turn_valid = 1'b0;
      turn_error = 1'b0;
      if (!reset_n) begin
        gen_pending = 1'b0;
        glitch_next = 1'b0;
        turn_ready  = 1'b0;
      end else begin
        turn_ready = (gen_mode != MODE_STALL) && !gen_pending;
        if (glitch_next) begin
          turn_valid      = 1'b1;
          turn_board_a_in = '1;
          turn_board_b_in = '1;
          glitch_next     = 1'b0;
        end
        if (gen_pending) begin
          gen_count--;
          if (gen_count == 0) begin
            deliver();
            gen_pending = 1'b0;
            glitch_next = noise;
          end else if (noise) begin
            turn_error = 1'b1;
          end
        end else if (req_seen) begin
          checkOutput("offer_board_a", 32'(turn_board_a), 32'(mdl_a));
          checkOutput("offer_board_b", 32'(turn_board_b), 32'(mdl_b));
          checkOutput("offer_target_a", 32'(turn_target_a), 32'(mdl_mover_a));
          gen_pending = 1'b1;
          gen_count   = gen_latency;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_count++;
      if (turn_req === 1'b1) req_count++;
    end
  end

  task automatic beginGame(input bit fa, input int mode, input int lat, input int bad,
                           input int kind, input int err, input bit nz);
    @(negedge clk);
    gen_mode     = mode;
    gen_latency  = lat;
    bad_move     = bad;
    bad_kind     = kind;
    err_move     = err;
    noise        = nz;
    mdl_a        = '0;
    mdl_b        = '0;
    mdl_mover_a  = fa;
    mdl_moves    = 0;
    mdl_attempts = 0;
    exp_result   = 2'd0;
    exp_fault    = (mode == MODE_STALL);
    mdl_over     = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    first_a = fa;
    @(negedge clk);
    start   = 1'b0;
    first_a = 1'($urandom);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic applyStimulus(input bit fa, input int mode, input int lat, input int bad,
                               input int kind, input int err, input bit nz);
    int cycles, d0, r0;
    d0 = done_count;
    r0 = req_count;
    beginGame(fa, mode, lat, bad, kind, err, nz);
    cycles = 1;
    if (nz) begin
      repeat (4) @(negedge clk);
      start   = 1'b1;
      first_a = !fa;
      @(negedge clk);
      start   = 1'b0;
      cycles += 5;
    end
    while (done !== 1'b1 && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("done_within_budget", 32'(done), 32'd1);
    last_cycles = cycles;
    repeat (3) @(negedge clk);
    checkOutput("result", 32'(result), 32'(exp_result));
    checkOutput("fault", 32'(fault), 32'(exp_fault));
    checkOutput("board_a", 32'(board_a), 32'(mdl_a));
    checkOutput("board_b", 32'(board_b), 32'(mdl_b));
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("done_pulses", 32'(done_count - d0), 32'd1);
    checkOutput("turn_req_count", 32'(req_count - r0), 32'(mdl_attempts));
  endtask

  initial begin
    int cycles, d0, sel, bad, kind, err, lat;
    bit fa, nz;
    reset_n = 1'b1;
    start   = 1'b0;
    first_a = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_turn_req", 32'(turn_req), 32'd0);
    checkOutput("reset_board_a", 32'(board_a), 32'd0);
    checkOutput("reset_board_b", 32'(board_b), 32'd0);
    checkOutput("reset_result", 32'(result), 32'd0);
    checkOutput("reset_fault", 32'(fault), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] A first, lowest free cell");
    applyStimulus(1'b1, MODE_LOWEST, 3, NONE, 0, NONE, 1'b0);
    checkOutput("a_first_result", 32'(result), 32'd1);
    checkOutput("a_first_board_a", 32'(board_a), 32'h055);
    checkOutput("a_first_board_b", 32'(board_b), 32'h02A);
    checkOutput("a_first_fault", 32'(fault), 32'd0);

    $display("[TB] B first, lowest free cell");
    applyStimulus(1'b0, MODE_LOWEST, 3, NONE, 0, NONE, 1'b0);
    checkOutput("b_first_result", 32'(result), 32'd2);
    checkOutput("b_first_board_b", 32'(board_b), 32'h055);
    checkOutput("b_first_board_a", 32'(board_a), 32'h02A);

    $display("[TB] double-bit move on third turn");
    applyStimulus(1'b1, MODE_LOWEST, 3, 2, 0, NONE, 1'b0);
    checkOutput("double_fault", 32'(fault), 32'd1);
    checkOutput("double_result", 32'(result), 32'd0);
    checkOutput("double_board_a", 32'(board_a), 32'h001);
    checkOutput("double_board_b", 32'(board_b), 32'h002);

    $display("[TB] generator never ready");
    applyStimulus(1'b1, MODE_STALL, 3, NONE, 0, NONE, 1'b0);
    checkOutput("stall_fault", 32'(fault), 32'd1);
    checkOutput("stall_elapsed_ok",
                32'(last_cycles >= TIMEOUT && last_cycles <= TIMEOUT + 1), 32'd1);

    $display("[TB] scripted draw");
    script = '{0, 2, 1, 3, 5, 4, 6, 7, 8};
    applyStimulus(1'b1, MODE_SCRIPT, 2, NONE, 0, NONE, 1'b0);
    checkOutput("draw_result", 32'(result), 32'd3);
    checkOutput("draw_fault", 32'(fault), 32'd0);
    checkOutput("draw_board_a", 32'(board_a), 32'h163);
    checkOutput("draw_board_b", 32'(board_b), 32'h09C);

    $display("[TB] generator error on fifth move");
    applyStimulus(1'b0, MODE_LOWEST, 1, NONE, 0, 4, 1'b1);
    checkOutput("gen_err_result", 32'(result), 32'd0);

    $display("[TB] illegal move kinds");
    for (int k = 1; k < 4; k++) applyStimulus(1'b1, MODE_RANDOM, 2, 3, k, NONE, 1'b1);

    $display("[TB] reset during fourth move");
    d0 = done_count;
    beginGame(1'b1, MODE_LOWEST, 3, NONE, 0, NONE, 1'b0);
    cycles = 0;
    while (!(mdl_moves == 3 && gen_pending) && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("reached_move4", 32'(mdl_moves == 3 && gen_pending), 32'd1);
    @(posedge clk);
    #2;
    checkOutput("busy_before_reset", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_board_a", 32'(board_a), 32'd0);
    checkOutput("midreset_board_b", 32'(board_b), 32'd0);
    checkOutput("midreset_turn_req", 32'(turn_req), 32'd0);
    checkOutput("midreset_result", 32'(result), 32'd0);
    checkOutput("midreset_fault", 32'(fault), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset_no_done", 32'(done_count - d0), 32'd0);
    applyStimulus(1'b1, MODE_LOWEST, 3, NONE, 0, NONE, 1'b0);
    checkOutput("replay_result", 32'(result), 32'd1);
    checkOutput("replay_board_a", 32'(board_a), 32'h055);
    checkOutput("replay_board_b", 32'(board_b), 32'h02A);

    $display("[TB] randomized games");
    for (int g = 0; g < 12; g++) begin
      fa   = 1'($urandom);
      lat  = $urandom_range(1, 4);
      sel  = $urandom_range(0, 2);
      bad  = NONE;
      kind = 0;
      err  = NONE;
      if (sel == 1) begin
        bad  = $urandom_range(0, 6);
        kind = $urandom_range(0, 3);
      end else if (sel == 2) begin
        err = $urandom_range(0, 8);
      end
      nz = (sel == 0) || (sel == 1 && bad >= 3) || (sel == 2 && err >= 3);
      applyStimulus(fa, MODE_RANDOM, lat, bad, kind, err, nz);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
